e203_exu_alu_dpath_seq: RTL

E203_EXU_ALU_DPATH_SEQ -- requirements
Module: e203_exu_alu_dpath_seq

---
 rtl/e203_exu_alu_dpath_seq.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/e203_exu_alu_dpath_seq.sv
// e203_exu_alu_dpath_seq
// Sequential ALU datapath with a valid/ready request and response handshake.
// It supports add, sub, xor, sll, srl, sra, or, and, slt, sltu and lui.
//
// Optional feature macro: E203_ALU_DPATH_FAST_SHIFT_EN
//   defined   : shifts use a single-cycle barrel shifter, and every op has a
//               latency of 1 cycle.
//   undefined : shifts with a non-zero amount step one bit per cycle in the
//               SHIFT state, giving a latency of 1 + shamt cycles.
// A req_op that is zero or has more than one bit set returns res=0, err=1.

module e203_exu_alu_dpath_seq #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [10:0]     req_op,
    input  logic [XLEN-1:0] req_op1,
    input  logic [XLEN-1:0] req_op2,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [XLEN-1:0] resp_res,
    output logic            resp_err,
    output logic            busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        RESP  = 2'd2
    } state_e;

    // Shift direction codes held in shk_q while the shift iterates
    localparam logic [1:0] SHK_SLL = 2'd0;
    localparam logic [1:0] SHK_SRL = 2'd1;
    localparam logic [1:0] SHK_SRA = 2'd2;

    state_e          state_q, state_d;
    logic [XLEN-1:0] res_q, res_d;
    logic            err_q, err_d;
    logic [XLEN-1:0] sh_q, sh_d;
    logic [4:0]      cnt_q, cnt_d;
    logic [1:0]      shk_q, shk_d;

    logic            accept;
    logic            opOneHot;
    logic [4:0]      shamt;
    logic [XLEN-1:0] aluRes;
    logic [XLEN-1:0] shStep;
    logic            sltBit;
    logic            sltuBit;
`ifndef E203_ALU_DPATH_FAST_SHIFT_EN
    logic            isShift;
`endif

    assign shamt     = req_op2[4:0];
    assign opOneHot  = (req_op != 11'd0) && ((req_op & (req_op - 11'd1)) == 11'd0);
    assign sltBit    = $signed(req_op1) < $signed(req_op2);
    assign sltuBit   = req_op1 < req_op2;
    assign req_ready = (state_q == IDLE) || ((state_q == RESP) && resp_ready);
    assign accept    = req_valid && req_ready;
`ifndef E203_ALU_DPATH_FAST_SHIFT_EN
    assign isShift   = req_op[3] || req_op[4] || req_op[5];
`endif

    assign resp_valid = (state_q == RESP);
    assign resp_res   = res_q;
    assign resp_err   = err_q;
    assign busy       = (state_q != IDLE);

    // Single-cycle result of the requested op (meaningful only when one-hot)
    always_comb begin
        aluRes = '0;
        if (req_op[0]) begin
            aluRes = req_op1 + req_op2;
        end else if (req_op[1]) begin
            aluRes = req_op1 - req_op2;
        end else if (req_op[2]) begin
            aluRes = req_op1 ^ req_op2;
        end else if (req_op[3]) begin
`ifdef E203_ALU_DPATH_FAST_SHIFT_EN
            aluRes = req_op1 << shamt;
`else
            aluRes = req_op1;
`endif
        end else if (req_op[4]) begin
`ifdef E203_ALU_DPATH_FAST_SHIFT_EN
            aluRes = req_op1 >> shamt;
`else
            aluRes = req_op1;
`endif
        end else if (req_op[5]) begin
`ifdef E203_ALU_DPATH_FAST_SHIFT_EN
            aluRes = $unsigned($signed(req_op1) >>> shamt);
`else
            aluRes = req_op1;
`endif
        end else if (req_op[6]) begin
            aluRes = req_op1 | req_op2;
        end else if (req_op[7]) begin
            aluRes = req_op1 & req_op2;
        end else if (req_op[8]) begin
            aluRes = {{(XLEN-1){1'b0}}, sltBit};
        end else if (req_op[9]) begin
            aluRes = {{(XLEN-1){1'b0}}, sltuBit};
        end else if (req_op[10]) begin
            aluRes = req_op2;
        end
    end

    // One-bit step of the iterative shifter; sra replicates the sign bit
    always_comb begin
        shStep = sh_q;
        case (shk_q)
            SHK_SLL: shStep = sh_q << 1;
            SHK_SRL: shStep = sh_q >> 1;
            default: shStep = {sh_q[XLEN-1], sh_q[XLEN-1:1]};
        endcase
    end

    // Next-state logic; a new accept overrides whatever RESP would do next
    always_comb begin
        state_d = state_q;
        res_d   = res_q;
        err_d   = err_q;
        sh_d    = sh_q;
        cnt_d   = cnt_q;
        shk_d   = shk_q;

        case (state_q)
            IDLE: begin
                state_d = IDLE;
            end
            SHIFT: begin
                sh_d  = shStep;
                cnt_d = cnt_q - 5'd1;
                if (cnt_q == 5'd1) begin
                    state_d = RESP;
                    res_d   = shStep;
                    err_d   = 1'b0;
                end
            end
            RESP: begin
                if (resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (accept) begin
            if (!opOneHot) begin
                state_d = RESP;
                res_d   = '0;
                err_d   = 1'b1;
`ifndef E203_ALU_DPATH_FAST_SHIFT_EN
            end else if (isShift && (shamt != 5'd0)) begin
                state_d = SHIFT;
                sh_d    = req_op1;
                cnt_d   = shamt;
                err_d   = 1'b0;
                if (req_op[4]) begin
                    shk_d = SHK_SRL;
                end else if (req_op[5]) begin
                    shk_d = SHK_SRA;
                end else begin
                    shk_d = SHK_SLL;
                end
`endif
            end else begin
                state_d = RESP;
                res_d   = aluRes;
                err_d   = 1'b0;
            end
        end
    end

    // State registers; reset drops any in-flight work and returns to IDLE
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            res_q   <= '0;
            err_q   <= 1'b0;
            sh_q    <= '0;
            cnt_q   <= 5'd0;
            shk_q   <= SHK_SLL;
        end else begin
            state_q <= state_d;
            res_q   <= res_d;
            err_q   <= err_d;
            sh_q    <= sh_d;
            cnt_q   <= cnt_d;
            shk_q   <= shk_d;
        end
    end

endmodule
